aes128_dec_ctrl: RTL and testbench

Iterative AES-128 decryption controller. It expands a loaded cipher key once, storing round keys k0..k10 in a key register file. It then decrypts one 128-bit block per request by applying one shared `invround` instance for 9 cycles, with the key order reversed, followed by one `invlastround`. It replaces the fully unrolled 10-round decryption datapath where area matters, and sits between the host-side data/key interfaces and the round primitives `Key_Expansion`, `invround` and `invlastround`.

---
 rtl/aes128_dec_ctrl_if.sv | 23 ++
 rtl/aes128_dec_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_aes128_dec_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_dec_ctrl_if.sv
// aes128_dec_ctrl_if: key, ciphertext and plaintext handshakes.
// master = host side, slave = decryption controller.
interface aes128_dec_ctrl_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output key_in, key_valid, data_in, in_valid, out_ready,
    input  key_ready, in_ready, data_out, out_valid
  );

  modport slave (
    input  key_in, key_valid, data_in, in_valid, out_ready,
    output key_ready, in_ready, data_out, out_valid
  );
endinterface

// File: rtl/aes128_dec_ctrl.sv
// aes128_dec_ctrl: iterative AES-128 decrypt, one shared inverse round.
// Option AES_DEC_ZEROIZE_EN: wipe keys/state after every output.
module aes128_dec_ctrl (
  input  logic               clk,
  input  logic               reset_n,
  aes128_dec_ctrl_if.slave   bus,
  output logic               key_loaded,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, READY, ROUND, LAST, DONE
  } st_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, x;
    r = 8'h01;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gm(r, x);
      x = gm(x, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
  endfunction

  // byte j sits at [127-8j -: 8]; column c holds bytes 4c..4c+3
  function automatic logic [127:0] isr_isb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] imix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b)
                       ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
      o[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e)
                       ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
      o[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09)
                       ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
      o[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d)
                       ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] invround(input logic [127:0] s,
                                            input logic [127:0] k);
    return imix(isr_isb(s) ^ k);
  endfunction

  function automatic logic [127:0] invlastround(input logic [127:0] s,
                                                input logic [127:0] k);
    return isr_isb(s) ^ k;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k,
                                           input logic [7:0]   rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
       ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  st_t          r_st, w_nx;
  logic [127:0] r_key [0:10];
  logic [3:0]   r_kcnt, r_rcnt;
  logic [127:0] r_blk, r_dout;
  logic         r_ovld, r_kld;
  logic         w_kr, w_ir, w_busy;
  logic         w_khs, w_ihs, w_ohs;
  logic [127:0] w_kexp, w_rnd, w_last;

  assign w_khs  = bus.key_valid & w_kr;
  assign w_ihs  = bus.in_valid & w_ir;
  assign w_ohs  = r_ovld & bus.out_ready;
  assign w_kexp = key_exp(r_key[r_kcnt - 4'd1], rcon(r_kcnt));
  assign w_rnd  = invround(r_blk, r_key[4'd10 - r_rcnt]);
  assign w_last = invlastround(r_blk, r_key[0]);

  assign bus.key_ready = w_kr;
  assign bus.in_ready  = w_ir;
  assign bus.data_out  = r_dout;
  assign bus.out_valid = r_ovld;
  assign key_loaded    = r_kld;
  assign busy          = w_busy;

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_st <= IDLE;
    else          r_st <= w_nx;

  // next-state logic
  always_comb begin
    w_nx = r_st;
    case (r_st)
      IDLE:    if (w_khs) w_nx = KEYEXP;
      KEYEXP:  if (r_kcnt == 4'd11) w_nx = READY;
      READY:   if (w_khs) w_nx = KEYEXP;
               else if (w_ihs) w_nx = ROUND;
      ROUND:   if (r_rcnt == 4'd9) w_nx = LAST;
      LAST:    w_nx = DONE;
      DONE:
`ifdef AES_DEC_ZEROIZE_EN
               if (w_ohs) w_nx = IDLE;
`else
               if (w_ohs) w_nx = READY;
`endif
      default: w_nx = IDLE;
    endcase
  end

  // handshake readiness and busy flag; a pending key masks in_ready
  always_comb begin
    w_kr   = 1'b0;
    w_ir   = 1'b0;
    w_busy = 1'b0;
    unique case (1'b1)
      (r_st == IDLE):  w_kr = 1'b1;
      (r_st == READY): begin
        w_kr = 1'b1;
        w_ir = ~bus.key_valid;
      end
      (r_st == KEYEXP),
      (r_st == ROUND),
      (r_st == LAST):  w_busy = 1'b1;
      default:         w_busy = 1'b0;
    endcase
  end

  // key file: k0 on key handshake, k1..k10 expanded one per cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) r_key[i] <= '0;
    end else if (w_khs) begin
      r_key[0] <= bus.key_in;
    end else if (r_st == KEYEXP && r_kcnt <= 4'd10) begin
      r_key[r_kcnt] <= w_kexp;
`ifdef AES_DEC_ZEROIZE_EN
    end else if (r_st == DONE && w_ohs) begin
      for (int i = 0; i < 11; i++) r_key[i] <= '0;
`endif
    end

  // key counter and key_loaded flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_kcnt <= '0;
      r_kld  <= 1'b0;
    end else if (w_khs) begin
      r_kcnt <= 4'd1;
      r_kld  <= 1'b0;
    end else if (r_st == KEYEXP) begin
      r_kcnt <= r_kcnt + 4'd1;
      if (r_kcnt == 4'd11) r_kld <= 1'b1;
`ifdef AES_DEC_ZEROIZE_EN
    end else if (r_st == DONE && w_ohs) begin
      r_kld <= 1'b0;
`endif
    end

  // block state and round counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_blk  <= '0;
      r_rcnt <= '0;
    end else if (w_ihs) begin
      r_blk  <= bus.data_in ^ r_key[10];
      r_rcnt <= 4'd1;
    end else if (r_st == ROUND) begin
      r_blk  <= w_rnd;
      r_rcnt <= r_rcnt + 4'd1;
    end else if (r_st == LAST) begin
      r_blk  <= w_last;
`ifdef AES_DEC_ZEROIZE_EN
    end else if (r_st == DONE && w_ohs) begin
      r_blk  <= '0;
`endif
    end

  // output register held through back-pressure
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_dout <= '0;
      r_ovld <= 1'b0;
    end else if (r_st == LAST) begin
      r_dout <= w_last;
      r_ovld <= 1'b1;
    end else if (w_ohs) begin
      r_ovld <= 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
      r_dout <= '0;
`endif
    end

endmodule

// File: tb/tb_aes128_dec_ctrl.sv
// tb_aes128_dec_ctrl: scoreboard bench for aes128_dec_ctrl.
// Honours AES_DEC_ZEROIZE_EN when defined.
module tb_aes128_dec_ctrl;

  localparam logic [127:0] KA  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CTA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PTA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB0 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PB1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CB2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PB2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CB3 = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] PB3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CTZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic key_loaded, busy;

  aes128_dec_ctrl_if bus ();

  aes128_dec_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .key_loaded (key_loaded),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] sbq [$];
  logic [127:0] cur_key = '0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // monitor: every output handshake pops one expected plaintext
  always @(negedge clk)
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h want none", bus.data_out);
      end else begin
        chk("data_out", bus.data_out, sbq.pop_front());
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_kl(input string nm);
    int n;
    n = 0;
    while (!key_loaded && n < 30) begin
      tick();
      n++;
    end
    chki(nm, n, 11);
  endtask

  task automatic load_key(input logic [127:0] k);
    bit ok;
    ok = 0;
    cur_key = k;
    bus.key_in = k;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.key_ready) ok = 1;
    end
    chkb("key_hs", ok, 1'b1);
    tick();
    bus.key_valid = 1'b0;
    chkb("busy_kexp", busy, 1'b1);
    wait_kl("key_lat");
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                      input bit push, input bit lat);
    bit ok;
    int n;
`ifdef AES_DEC_ZEROIZE_EN
    if (!key_loaded) load_key(cur_key);
`endif
    ok = 0;
    bus.data_in = ct;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    chkb("blk_hs", ok, 1'b1);
    if (push) sbq.push_back(pt);
    tick();
    bus.in_valid = 1'b0;
    if (lat) begin
      n = 0;
      while (!bus.out_valid && n < 30) begin
        tick();
        n++;
      end
      chki("blk_lat", n, 10);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chki("drain", sbq.size(), 0);
  endtask

  initial begin
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.data_in   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    chkb("rst_key_ready", bus.key_ready, 1'b1);
    chkb("rst_in_ready", bus.in_ready, 1'b0);
    chkb("rst_out_valid", bus.out_valid, 1'b0);
    chkb("rst_key_loaded", key_loaded, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_data_out", bus.data_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    load_key(KA);
    send(CTA, PTA, 1, 1);
    drain();

    bus.out_ready = 1'b0;
    send(CTA, PTA, 1, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chkb("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data", bus.data_out, PTA);
      chkb("bp_in_ready", bus.in_ready, 1'b0);
    end
    tick();
    bus.out_ready = 1'b1;
    drain();

    cur_key = '0;
    bus.key_in = '0;
    bus.key_valid = 1'b1;
    bus.data_in = CTZ;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chkb("both_in_ready", bus.in_ready, 1'b0);
    chkb("both_key_ready", bus.key_ready, 1'b1);
    tick();
    bus.key_valid = 1'b0;
    bus.in_valid = 1'b0;
    chkb("both_busy", busy, 1'b1);
    chkb("both_kl", key_loaded, 1'b0);
    wait_kl("both_key_lat");
    chkb("both_no_out", bus.out_valid, 1'b0);
    send(CTZ, '0, 1, 1);
    drain();

    load_key(KB);
    send(CB0, PB0, 1, 1);
    send(CB1, PB1, 1, 0);
    send(CB2, PB2, 1, 0);
    send(CB3, PB3, 1, 1);
    drain();

    send(CB0, PB0, 0, 0);
    repeat (5) tick();
    chkb("r5_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chkb("ar_key_ready", bus.key_ready, 1'b1);
    chkb("ar_in_ready", bus.in_ready, 1'b0);
    chkb("ar_out_valid", bus.out_valid, 1'b0);
    chkb("ar_key_loaded", key_loaded, 1'b0);
    chkb("ar_busy", busy, 1'b0);
    chk("ar_data_out", bus.data_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chkb("post_rst_kr", bus.key_ready, 1'b1);
    chkb("post_rst_ir", bus.in_ready, 1'b0);
    repeat (15) tick();
    chkb("post_rst_out", bus.out_valid, 1'b0);

    load_key(KA);
    send(CTA, PTA, 1, 1);
    drain();
`ifdef AES_DEC_ZEROIZE_EN
    chkb("zz_kl", key_loaded, 1'b0);
    chk("zz_data", bus.data_out, '0);
    bus.data_in = CTA;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb("zz_in_ready", bus.in_ready, 1'b0);
    end
    tick();
    bus.in_valid = 1'b0;
    send(CTA, PTA, 1, 1);
    drain();
`else
    chkb("keep_kl", key_loaded, 1'b1);
    chk("keep_data", bus.data_out, PTA);
    chkb("keep_in_ready", bus.in_ready, 1'b1);
    send(CTA, PTA, 1, 1);
    drain();
`endif

    repeat (3) tick();
    chki("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
